// File: rtl/dm_byte_lane.sv
// dm_byte_lane
// Data memory for the MIPS MEM stage with byte-lane stores, sign/zero
// extended sub-word loads, alignment/range checking with a sticky fault
// capture, and a hardware sweep that zeroes the array after reset.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (any positive value)
//   BASE_ADDR    byte address of word 0 (word-aligned)
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   req_valid    access presented this cycle
//   req_write    1 = store, 0 = load
//   req_size     0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   Addr         byte address
//   WriteData    right-aligned store data
//   ReadData     extended load result (combinational)
//   ready        array usable (clear sweep finished)
//   addr_err     current request faults (combinational)
//   err_valid    sticky: a fault has been captured
//   err_addr     address of the first captured fault
module dm_byte_lane #(
  parameter int unsigned DEPTH_WORDS = 12288,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        addr_err,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int unsigned   PW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]   DEPTH32 = 32'(DEPTH_WORDS);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH_WORDS - 1);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [0:0]    state;
  logic [PW-1:0] ptr;

  logic [31:0]   offset;
  logic [31:0]   wordIdx32;
  logic [PW-1:0] idx;
  logic          inRange;
  logic          misaligned;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic [15:0]   rdHalf;
  logic [3:0]    laneEn;
  logic [31:0]   laneData;
  logic          storeEn;

  // Address decode. The subtraction may wrap when Addr is below the base,
  // so the explicit lower-bound compare is what keeps such addresses out.
  always_comb begin
    offset    = Addr - BASE_ADDR;
    wordIdx32 = {2'b00, offset[31:2]};
    idx       = wordIdx32[PW-1:0];
    inRange   = (Addr >= BASE_ADDR) && (wordIdx32 < DEPTH32);
  end

  // Alignment rules per access size; size 3 is always a fault.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = Addr[0];
      2'd2:    misaligned = (Addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign addr_err = req_valid & (misaligned | ~inRange);
  assign ready    = (state == IDLE);
  assign storeEn  = (state == IDLE) & req_valid & req_write & ~addr_err;

  // Load path: pick the addressed lane(s), right-align, then extend.
  // Out-of-range indices never reach the array.
  always_comb begin
    rdWord   = inRange ? mem[idx] : 32'h0;
    rdByte   = rdWord[{Addr[1:0], 3'b000} +: 8];
    rdHalf   = Addr[1] ? rdWord[31:16] : rdWord[15:0];
    ReadData = 32'h0;
    if ((state == IDLE) && req_valid && !addr_err) begin
      case (req_size)
        2'd0:    ReadData = req_unsigned ? {24'h0, rdByte} : {{24{rdByte[7]}}, rdByte};
        2'd1:    ReadData = req_unsigned ? {16'h0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
        2'd2:    ReadData = rdWord;
        default: ReadData = 32'h0;
      endcase
    end
  end

  // Store lane enables. Data is replicated across lanes so each enabled
  // lane simply takes its own byte slice.
  always_comb begin
    laneEn   = 4'b0000;
    laneData = WriteData;
    case (req_size)
      2'd0: begin
        laneEn   = 4'b0001 << Addr[1:0];
        laneData = {4{WriteData[7:0]}};
      end
      2'd1: begin
        laneEn   = Addr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{WriteData[15:0]}};
      end
      2'd2: begin
        laneEn   = 4'b1111;
        laneData = WriteData;
      end
      default: begin
        laneEn   = 4'b0000;
        laneData = WriteData;
      end
    endcase
  end

  // Clear sequencer: one word zeroed per edge, moving to IDLE on the edge
  // that writes the last word. IDLE is only left through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      if (ptr == LAST) begin
        state <= IDLE;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

  // Sticky fault capture: only the first fault seen while ready is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
    end else if (addr_err && (state == IDLE) && !err_valid) begin
      err_valid <= 1'b1;
      err_addr  <= Addr;
    end
  end

  // Array writes. The sweep owns the array during CLEAR, so requests
  // presented then never reach it.
  always_ff @(posedge clk) begin
    if (reset && (state == CLEAR)) begin
      mem[ptr] <= 32'h0;
    end else if (storeEn) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) begin
          mem[idx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_byte_lane.sv
// tb_dm_byte_lane
// Testbench for dm_byte_lane. Two instances share the request inputs:
// dut0 with base 0 and dut1 with base 0x1000, both 16 words deep.
module tb_dm_byte_lane;

  typedef struct {
    string       name;
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expErr;
    logic        chkSticky;
    logic        expErrValid;
    logic [31:0] expErrAddr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] Addr;
  logic [31:0] WriteData;

  logic [31:0] rd0, ea0, rd1, ea1;
  logic        rdy0, ae0, ev0, rdy1, ae1, ev1;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t tbl[$];
  vec_t sb[$];

  dm_byte_lane #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rd0), .ready(rdy0), .addr_err(ae0),
    .err_valid(ev0), .err_addr(ea0)
  );

  dm_byte_lane #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rd1), .ready(rdy1), .addr_err(ae1),
    .err_valid(ev1), .err_addr(ea1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic v, logic w, logic [1:0] s, logic u,
                              logic [31:0] a, logic [31:0] wd, logic cr,
                              logic [31:0] er, logic ee, logic cs, logic ev,
                              logic [31:0] ea);
    vec_t t;
    t.name = n; t.valid = v; t.wr = w; t.size = s; t.uns = u; t.addr = a;
    t.wdata = wd; t.chkRd = cr; t.expRd = er; t.expErr = ee;
    t.chkSticky = cs; t.expErrValid = ev; t.expErrAddr = ea;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_write    = w;
    req_size     = s;
    req_unsigned = u;
    Addr         = a;
    WriteData    = wd;
  endtask

  // Drive one request just after a rising edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    drive(v.valid, v.wr, v.size, v.uns, v.addr, v.wdata);
    sb.push_back(v);
  endtask

  // Compare dut0 against the oldest queued expectation at the falling edge.
  task automatic checkOutput();
    vec_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      if (e.chkRd) check({e.name, " ReadData"}, rd0, e.expRd);
      check({e.name, " addr_err"}, {31'h0, ae0}, {31'h0, e.expErr});
      if (e.chkSticky) begin
        check({e.name, " err_valid"}, {31'h0, ev0}, {31'h0, e.expErrValid});
        check({e.name, " err_addr"}, ea0, e.expErrAddr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk($sformatf("lw clear w%0d", i), 1, 0, 2'd2, 0, 32'(i*4), 0, 1, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk("sw 0x12345678@4",  1, 1, 2'd2, 0, 32'h04, 32'h12345678, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("lw @4",            1, 0, 2'd2, 0, 32'h04, 0, 1, 32'h12345678, 0, 0, 0, 0));
    tbl.push_back(mk("lb @5",            1, 0, 2'd0, 0, 32'h05, 0, 1, 32'h00000056, 0, 0, 0, 0));
    tbl.push_back(mk("lbu @7",           1, 0, 2'd0, 1, 32'h07, 0, 1, 32'h00000012, 0, 0, 0, 0));
    tbl.push_back(mk("sb 0x9A@6",        1, 1, 2'd0, 0, 32'h06, 32'hFFFFFF9A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lw @4 after sb",   1, 0, 2'd2, 0, 32'h04, 0, 1, 32'h129A5678, 0, 0, 0, 0));
    tbl.push_back(mk("lb @6",            1, 0, 2'd0, 0, 32'h06, 0, 1, 32'hFFFFFF9A, 0, 0, 0, 0));
    tbl.push_back(mk("lbu @6",           1, 0, 2'd0, 1, 32'h06, 0, 1, 32'h0000009A, 0, 0, 0, 0));
    tbl.push_back(mk("sw restore @4",    1, 1, 2'd2, 0, 32'h04, 32'h12345678, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sh 0xBEEF@6",      1, 1, 2'd1, 0, 32'h06, 32'hCAFEBEEF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lw @4 after sh",   1, 0, 2'd2, 0, 32'h04, 0, 1, 32'hBEEF5678, 0, 0, 0, 0));
    tbl.push_back(mk("lh @6",            1, 0, 2'd1, 0, 32'h06, 0, 1, 32'hFFFFBEEF, 0, 0, 0, 0));
    tbl.push_back(mk("lhu @6",           1, 0, 2'd1, 1, 32'h06, 0, 1, 32'h0000BEEF, 0, 0, 0, 0));
    tbl.push_back(mk("lh @4",            1, 0, 2'd1, 0, 32'h04, 0, 1, 32'h00005678, 0, 0, 0, 0));
    tbl.push_back(mk("sw misaligned @2", 1, 1, 2'd2, 0, 32'h02, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk("lw @0 unchanged",  1, 0, 2'd2, 0, 32'h00, 0, 1, 32'h00000000, 0, 1, 1, 32'h02));
    tbl.push_back(mk("lh odd @0x41",     1, 0, 2'd1, 0, 32'h41, 0, 1, 32'h00000000, 1, 1, 1, 32'h02));
    tbl.push_back(mk("lw after 2nd err", 1, 0, 2'd2, 0, 32'h04, 0, 1, 32'hBEEF5678, 0, 1, 1, 32'h02));
    tbl.push_back(mk("lw end @0x40",     1, 0, 2'd2, 0, 32'h40, 0, 1, 32'h00000000, 1, 0, 0, 0));
    tbl.push_back(mk("size3 @8",         1, 0, 2'd3, 0, 32'h08, 0, 1, 32'h00000000, 1, 0, 0, 0));
    tbl.push_back(mk("sb 0xA5@0x3F",     1, 1, 2'd0, 0, 32'h3F, 32'h000000A5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lbu @0x3F",        1, 0, 2'd0, 1, 32'h3F, 0, 1, 32'h000000A5, 0, 0, 0, 0));
    tbl.push_back(mk("lb @0x3F",         1, 0, 2'd0, 0, 32'h3F, 0, 1, 32'hFFFFFFA5, 0, 0, 0, 0));
    tbl.push_back(mk("lw @0x3C",         1, 0, 2'd2, 0, 32'h3C, 0, 1, 32'hA5000000, 0, 0, 0, 0));
    tbl.push_back(mk("no valid",         0, 0, 2'd2, 0, 32'h04, 0, 1, 32'h00000000, 0, 0, 0, 0));

    reset = 1'b0;
    drive(1, 0, 2'd2, 0, 32'h0, 32'h0);
    #12;
    check("reset ready", {31'h0, rdy0}, 32'h0);
    check("reset err_valid", {31'h0, ev0}, 32'h0);
    check("reset err_addr", ea0, 32'h0);
    check("reset ReadData", rd0, 32'h0);
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);

    // First sweep: ready must rise on exactly the 16th edge.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sweep1 ready k=%0d", k), {31'h0, rdy0}, {31'h0, (k == 16)});
    end

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // Non-zero base instance.
    @(posedge clk); #1;
    drive(1, 1, 2'd2, 0, 32'h0000_0FFC, 32'h11223344);
    @(negedge clk);
    check("base1 sw @0xFFC addr_err", {31'h0, ae1}, 32'h1);
    @(posedge clk); #1;
    drive(1, 1, 2'd2, 0, 32'h0000_1000, 32'h55667788);
    @(negedge clk);
    check("base1 sw @0x1000 addr_err", {31'h0, ae1}, 32'h0);
    @(posedge clk); #1;
    drive(1, 0, 2'd2, 0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    check("base1 lw @0x1000", rd1, 32'h55667788);
    @(posedge clk); #1;
    drive(1, 0, 2'd2, 0, 32'h0000_1004, 32'h0);
    @(negedge clk);
    check("base1 lw @0x1004", rd1, 32'h0);
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);

    // Reset mid-clear: a second reset pulse at sweep cycle 7 restarts it.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset2 ready", {31'h0, rdy0}, 32'h0);
    check("reset2 err_valid", {31'h0, ev0}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sweep2 ready k=%0d", k), {31'h0, rdy0}, {31'h0, (k == 16)});
      if (k == 6)  drive(1, 1, 2'd2, 0, 32'h08, 32'hDEADBEEF);
      if (k == 8)  drive(1, 1, 2'd2, 0, 32'h02, 32'hDEADBEEF);
      if (k == 10) drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
      if (k == 12) check("clear no capture err_valid", {31'h0, ev0}, 32'h0);
    end

    applyStimulus(mk("lw @8 after clear store", 1, 0, 2'd2, 0, 32'h08, 0, 1, 32'h0, 0, 1, 0, 0));
    checkOutput();
    applyStimulus(mk("lw @4 rezeroed", 1, 0, 2'd2, 0, 32'h04, 0, 1, 32'h0, 0, 1, 0, 0));
    checkOutput();
    drive(0, 0, 2'd0, 0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
